pc_sequencer: RTL and testbench

Owns the program counter and sequences instruction fetch for the processor core. It applies the signed branch/jump offset produced by the PC offset/target logic, and keeps a small return-address stack for call/return. It also runs the start/done handshake with the test harness. It sits between the decoder/ALU flag outputs and the instruction ROM address port.

---
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer with a small return-address stack and start/done handshake.
// One-cycle registered update; stall freezes PC, stack and state while running.
module pc_sequencer #(
    parameter int D           = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [D-1:0] start_addr,
    input  logic         stall,
    input  logic         branch_en,
    input  logic         branch_taken,
    input  logic [D-1:0] offset,
    input  logic         call,
    input  logic         ret,
    input  logic         halt_req,
    output logic [D-1:0] pc,
    output logic         done,
    output logic         fault,
    output logic [1:0]   state
);

    localparam int SPW = $clog2(STACK_DEPTH) + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_HALT  = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    state_t         r_state;
    logic [D-1:0]   r_pc;
    logic           r_done;
    logic           r_fault;
    logic [SPW-1:0] r_sp;
    logic [D-1:0]   r_stack [STACK_DEPTH];

    logic [D-1:0]   w_pc_inc;
    logic [D-1:0]   w_pc_tgt;
    logic [SPW-1:0] w_sp_dec;
    logic           w_run_go;
    logic           w_push;

    assign w_pc_inc = r_pc + 1'b1;
    assign w_pc_tgt = r_pc + offset;
    assign w_sp_dec = r_sp - 1'b1;
    assign w_run_go = (r_state == S_RUN) && !stall;
    // Push only when the call actually wins arbitration and the stack has room.
    assign w_push   = w_run_go && !halt_req && !ret && call && (r_sp != SP_FULL);

    // Stack contents need no reset; sp alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp[SPW-2:0]] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_sp    <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!stall) begin
                        if (halt_req) begin
                            r_state <= S_HALT;
                            r_done  <= 1'b1;
                        end else if (ret) begin
                            if (r_sp == '0) begin
                                r_state <= S_FAULT;
                                r_fault <= 1'b1;
                                r_done  <= 1'b1;
                            end else begin
                                r_pc <= r_stack[w_sp_dec[SPW-2:0]];
                                r_sp <= w_sp_dec;
                            end
                        end else if (call) begin
                            if (r_sp == SP_FULL) begin
                                r_state <= S_FAULT;
                                r_fault <= 1'b1;
                                r_done  <= 1'b1;
                            end else begin
                                r_pc <= w_pc_tgt;
                                r_sp <= r_sp + 1'b1;
                            end
                        end else if (branch_en && branch_taken) begin
                            r_pc <= w_pc_tgt;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_pc    <= start_addr;
                        r_sp    <= '0;
                        r_done  <= 1'b0;
                        r_fault <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pc    = r_pc;
    assign done  = r_done;
    assign fault = r_fault;
    assign state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: a sequential table of single-cycle steps plus an async-reset sequence.
module tb_pc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [11:0] start_addr;
    logic        stall;
    logic        branch_en;
    logic        branch_taken;
    logic [11:0] offset;
    logic        call;
    logic        ret;
    logic        halt_req;
    logic [11:0] pc;
    logic        done;
    logic        fault;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(.D(12), .STACK_DEPTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .start_addr   (start_addr),
        .stall        (stall),
        .branch_en    (branch_en),
        .branch_taken (branch_taken),
        .offset       (offset),
        .call         (call),
        .ret          (ret),
        .halt_req     (halt_req),
        .pc           (pc),
        .done         (done),
        .fault        (fault),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic [11:0] addr;
        logic        stl;
        logic        ben;
        logic        btk;
        logic [11:0] off;
        logic        cl;
        logic        rt;
        logic        hlt;
        logic [11:0] e_pc;
        logic        e_done;
        logic        e_fault;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vq[$];

    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10, FLT = 2'b11;

    function automatic vec_t mk(string n, logic st, logic [11:0] addr, logic stl, logic ben,
                                logic btk, logic [11:0] off, logic cl, logic rt, logic hlt,
                                logic [11:0] e_pc, logic e_done, logic e_fault, logic [1:0] e_state);
        vec_t v;
        v.name = n; v.st = st; v.addr = addr; v.stl = stl; v.ben = ben; v.btk = btk;
        v.off = off; v.cl = cl; v.rt = rt; v.hlt = hlt;
        v.e_pc = e_pc; v.e_done = e_done; v.e_fault = e_fault; v.e_state = e_state;
        return v;
    endfunction

    task automatic check(string n, logic [11:0] e_pc, logic e_done, logic e_fault, logic [1:0] e_state);
        checks++;
        if (pc !== e_pc || done !== e_done || fault !== e_fault || state !== e_state) begin
            failures++;
            $display("FAIL %s: got pc=%03h done=%0b fault=%0b state=%02b, want pc=%03h done=%0b fault=%0b state=%02b",
                     n, pc, done, fault, state, e_pc, e_done, e_fault, e_state);
        end
    endtask

    task automatic drive(vec_t v);
        start = v.st; start_addr = v.addr; stall = v.stl; branch_en = v.ben;
        branch_taken = v.btk; offset = v.off; call = v.cl; ret = v.rt; halt_req = v.hlt;
    endtask

    task automatic step(vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check(v.name, v.e_pc, v.e_done, v.e_fault, v.e_state);
    endtask

    initial begin
        //                name             st addr    stl ben btk off     cl rt hl  pc      dn fl state
        vq.push_back(mk("idle_hold",      0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, IDLE));
        vq.push_back(mk("start_010",      1, 12'h010, 0, 0, 0, 12'h000, 0, 0, 0, 12'h010, 0, 0, RUN));
        vq.push_back(mk("inc_011",        0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 12'h011, 0, 0, RUN));
        vq.push_back(mk("inc_012",        0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 12'h012, 0, 0, RUN));
        vq.push_back(mk("inc_013",        0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 12'h013, 0, 0, RUN));
        vq.push_back(mk("start_ign_run",  1, 12'h500, 0, 0, 0, 12'h000, 0, 0, 0, 12'h014, 0, 0, RUN));
        vq.push_back(mk("halt_014",       0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 1, 12'h014, 1, 0, HALT));
        vq.push_back(mk("halt_hold",      0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 12'h014, 1, 0, HALT));
        vq.push_back(mk("start_stl_halt", 1, 12'h020, 1, 0, 0, 12'h000, 0, 0, 0, 12'h020, 0, 0, RUN));
        vq.push_back(mk("br_neg5",        0, 12'h000, 0, 1, 1, 12'hFFB, 0, 0, 0, 12'h01B, 0, 0, RUN));
        vq.push_back(mk("br_not_taken",   0, 12'h000, 0, 1, 0, 12'hFFB, 0, 0, 0, 12'h01C, 0, 0, RUN));
        vq.push_back(mk("stall_over_hlt", 0, 12'h000, 1, 1, 1, 12'h005, 0, 0, 1, 12'h01C, 0, 0, RUN));
        vq.push_back(mk("stall_2",        0, 12'h000, 1, 0, 0, 12'h000, 1, 0, 0, 12'h01C, 0, 0, RUN));
        vq.push_back(mk("halt_01c",       0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 1, 12'h01C, 1, 0, HALT));
        vq.push_back(mk("start_030",      1, 12'h030, 0, 0, 0, 12'h000, 0, 0, 0, 12'h030, 0, 0, RUN));
        vq.push_back(mk("call_014",       0, 12'h000, 0, 0, 0, 12'h014, 1, 0, 0, 12'h044, 0, 0, RUN));
        vq.push_back(mk("inc_045",        0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 12'h045, 0, 0, RUN));
        vq.push_back(mk("ret_031",        0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 0, 12'h031, 0, 0, RUN));
        vq.push_back(mk("br_to_050",      0, 12'h000, 0, 1, 1, 12'h01F, 0, 0, 0, 12'h050, 0, 0, RUN));
        vq.push_back(mk("call_ret_uflow", 0, 12'h000, 0, 0, 0, 12'h010, 1, 1, 0, 12'h050, 1, 1, FLT));
        vq.push_back(mk("fault_hold",     0, 12'h000, 1, 1, 1, 12'h010, 0, 0, 0, 12'h050, 1, 1, FLT));
        vq.push_back(mk("start_100",      1, 12'h100, 0, 0, 0, 12'h000, 0, 0, 0, 12'h100, 0, 0, RUN));
        vq.push_back(mk("call_1",         0, 12'h000, 0, 0, 0, 12'h010, 1, 0, 0, 12'h110, 0, 0, RUN));
        vq.push_back(mk("call_2",         0, 12'h000, 0, 0, 0, 12'h010, 1, 0, 0, 12'h120, 0, 0, RUN));
        vq.push_back(mk("call_3",         0, 12'h000, 0, 0, 0, 12'h010, 1, 0, 0, 12'h130, 0, 0, RUN));
        vq.push_back(mk("call_4",         0, 12'h000, 0, 0, 0, 12'h010, 1, 0, 0, 12'h140, 0, 0, RUN));
        vq.push_back(mk("call_5_oflow",   0, 12'h000, 0, 0, 0, 12'h010, 1, 0, 0, 12'h140, 1, 1, FLT));
        vq.push_back(mk("start_000",      1, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, RUN));
        vq.push_back(mk("lifo_call_a",    0, 12'h000, 0, 0, 0, 12'h010, 1, 0, 0, 12'h010, 0, 0, RUN));
        vq.push_back(mk("lifo_call_b",    0, 12'h000, 0, 0, 0, 12'h010, 1, 0, 0, 12'h020, 0, 0, RUN));
        vq.push_back(mk("lifo_ret_b",     0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 0, 12'h011, 0, 0, RUN));
        vq.push_back(mk("lifo_ret_a",     0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 0, 12'h001, 0, 0, RUN));
        vq.push_back(mk("lifo_uflow",     0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 0, 12'h001, 1, 1, FLT));
        vq.push_back(mk("start_ffe",      1, 12'hFFE, 0, 0, 0, 12'h000, 0, 0, 0, 12'hFFE, 0, 0, RUN));
        vq.push_back(mk("inc_fff",        0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 12'hFFF, 0, 0, RUN));
        vq.push_back(mk("inc_wrap",       0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, RUN));
        vq.push_back(mk("br_2_wrapneg",   0, 12'h000, 0, 1, 1, 12'h002, 0, 0, 0, 12'h002, 0, 0, RUN));
        vq.push_back(mk("br_neg_wrap",    0, 12'h000, 0, 1, 1, 12'hFFB, 0, 0, 0, 12'hFFD, 0, 0, RUN));
        vq.push_back(mk("br_to_fff",      0, 12'h000, 0, 1, 1, 12'h002, 0, 0, 0, 12'hFFF, 0, 0, RUN));
        vq.push_back(mk("call_wrap",      0, 12'h000, 0, 0, 0, 12'h002, 1, 0, 0, 12'h001, 0, 0, RUN));
        vq.push_back(mk("ret_wrap_000",   0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 0, 12'h000, 0, 0, RUN));
        vq.push_back(mk("br_off0_hold",   0, 12'h000, 0, 1, 1, 12'h000, 0, 0, 0, 12'h000, 0, 0, RUN));
        vq.push_back(mk("halt_over_br",   0, 12'h000, 0, 1, 1, 12'h005, 0, 0, 1, 12'h000, 1, 0, HALT));
        vq.push_back(mk("restart_234",    1, 12'h234, 0, 0, 0, 12'h000, 0, 0, 0, 12'h234, 0, 0, RUN));
        vq.push_back(mk("br_to_123",      0, 12'h000, 0, 1, 1, 12'hEEF, 0, 0, 0, 12'h123, 0, 0, RUN));

        reset_n = 1'b1;
        drive(mk("zero", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        #1 reset_n = 1'b0;
        #2 check("reset_initial", 12'h000, 1'b0, 1'b0, IDLE);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vq[i]) step(vq[i]);

        // Async reset mid-RUN at pc=0x123, observed before any clock edge.
        @(negedge clk);
        drive(mk("zero", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        #1 reset_n = 1'b0;
        #1 check("reset_mid_run", 12'h000, 1'b0, 1'b0, IDLE);
        #1 reset_n = 1'b1;
        step(mk("post_reset_1", 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, IDLE));
        step(mk("post_reset_2", 0, 12'h000, 1, 1, 1, 12'h005, 1, 0, 0, 12'h000, 0, 0, IDLE));
        step(mk("start_040",    1, 12'h040, 0, 0, 0, 12'h000, 0, 0, 0, 12'h040, 0, 0, RUN));
        step(mk("ret_after_rst",0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 0, 12'h040, 1, 1, FLT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
